// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM encoding, register
// index constants and the packed bundle of per-register hold/flush controls.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned STATE_W = 2;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN      = 2'd0,
        ST_DIV_WAIT = 2'd1,
        ST_IO_WAIT  = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic pc_hold;
        logic if_id_hold;
        logic id_ex_hold;
        logic ex_mem_hold;
        logic mem_wb_hold;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic pc_sel_redirect;
        logic div_abort;
    } ctrl_out_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs from the pipeline and hold/flush/redirect controls back to it.
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;

    logic [REG_W-1:0]   ID_Rs;
    logic [REG_W-1:0]   ID_Rt;
    logic               ID_Uses_Rt;
    logic               ID_EX_MemIOtoReg;
    logic               ID_EX_RegWrite;
    logic [REG_W-1:0]   ID_EX_Waddr;
    logic               EX_Div_Start;
    logic               EX_Div_Done;
    logic               MEM_IO_Access;
    logic               MEM_Redirect;

    logic               PC_Hold;
    logic               IF_ID_Hold;
    logic               ID_EX_Hold;
    logic               EX_MEM_Hold;
    logic               MEM_WB_Hold;
    logic               IF_ID_Flush;
    logic               ID_EX_Flush;
    logic               EX_MEM_Flush;
    logic               PC_Sel_Redirect;
    logic               Div_Abort;
    logic [STATE_W-1:0] Ctrl_State;

    // Pipeline side
    modport master (
        output ID_Rs, ID_Rt, ID_Uses_Rt, ID_EX_MemIOtoReg, ID_EX_RegWrite, ID_EX_Waddr,
               EX_Div_Start, EX_Div_Done, MEM_IO_Access, MEM_Redirect,
        input  PC_Hold, IF_ID_Hold, ID_EX_Hold, EX_MEM_Hold, MEM_WB_Hold,
               IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, PC_Sel_Redirect, Div_Abort, Ctrl_State
    );

    // Hazard controller side
    modport slave (
        input  ID_Rs, ID_Rt, ID_Uses_Rt, ID_EX_MemIOtoReg, ID_EX_RegWrite, ID_EX_Waddr,
               EX_Div_Start, EX_Div_Done, MEM_IO_Access, MEM_Redirect,
        output PC_Hold, IF_ID_Hold, ID_EX_Hold, EX_MEM_Hold, MEM_WB_Hold,
               IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, PC_Sel_Redirect, Div_Abort, Ctrl_State
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use compare: a load in EX whose destination is a source of the ID instruction.
module pipeline_hazard_ctrl_hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_load,
    input  logic             ex_reg_write,
    input  logic [REG_W-1:0] ex_waddr,
    output logic             load_use_c
);

    logic rs_match_c;
    logic rt_match_c;

    assign rs_match_c = (ex_waddr == id_rs);
    assign rt_match_c = id_uses_rt && (ex_waddr == id_rt);

    // $0 is never a real dependency
    assign load_use_c = ex_load && ex_reg_write && (ex_waddr != REG_ZERO)
                        && (rs_match_c || rt_match_c);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: redirect flush, IO wait states,
// divide wait and load-use interlock, decided combinationally each cycle.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned IO_WAIT = 2,
    parameter int unsigned CNT_W   = 4
)
(
    input  logic                 clock,
    input  logic                 reset,
    pipeline_hazard_ctrl_if.slave hz
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IO_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic             IO_EN    = (IO_WAIT != 0);

    ctrl_state_e      state;
    ctrl_state_e      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             div_pend;
    logic             div_pend_nxt;
    logic             done_seen;
    logic             done_seen_nxt;
    logic             load_use_c;
    logic             div_new_c;
    ctrl_out_t        out_c;

    pipeline_hazard_ctrl_hazard_detect u_hazard_detect (
        .id_rs        (hz.ID_Rs),
        .id_rt        (hz.ID_Rt),
        .id_uses_rt   (hz.ID_Uses_Rt),
        .ex_load      (hz.ID_EX_MemIOtoReg),
        .ex_reg_write (hz.ID_EX_RegWrite),
        .ex_waddr     (hz.ID_EX_Waddr),
        .load_use_c   (load_use_c)
    );

    // A divide that finishes in its issue cycle never needs a wait
    assign div_new_c = hz.EX_Div_Start && !hz.EX_Div_Done;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_RUN;
            cnt       <= '0;
            div_pend  <= 1'b0;
            done_seen <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            div_pend  <= div_pend_nxt;
            done_seen <= done_seen_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        div_pend_nxt  = div_pend;
        done_seen_nxt = done_seen;
        out_c         = '0;

        if (reset) begin
            out_c.if_id_flush  = 1'b1;
            out_c.id_ex_flush  = 1'b1;
            out_c.ex_mem_flush = 1'b1;
            out_c.div_abort    = 1'b1;
        end else if (hz.MEM_Redirect) begin
            // Everything younger than MEM is wrong-path, including a divide held behind IO
            out_c.pc_sel_redirect = 1'b1;
            out_c.if_id_flush     = 1'b1;
            out_c.id_ex_flush     = 1'b1;
            out_c.ex_mem_flush    = 1'b1;
            out_c.div_abort       = (state == ST_DIV_WAIT) || hz.EX_Div_Start
                                    || ((state == ST_IO_WAIT) && div_pend);
            state_nxt     = ST_RUN;
            cnt_nxt       = '0;
            div_pend_nxt  = 1'b0;
            done_seen_nxt = 1'b0;
        end else begin
            case (state)
                ST_IO_WAIT: begin
                    if (hz.EX_Div_Done) begin
                        done_seen_nxt = 1'b1;
                    end
                    if (cnt > CNT_ONE) begin
                        out_c.pc_hold     = 1'b1;
                        out_c.if_id_hold  = 1'b1;
                        out_c.id_ex_hold  = 1'b1;
                        out_c.ex_mem_hold = 1'b1;
                        out_c.mem_wb_hold = 1'b1;
                        cnt_nxt           = cnt - CNT_ONE;
                    end else begin
                        cnt_nxt       = '0;
                        div_pend_nxt  = 1'b0;
                        done_seen_nxt = 1'b0;
                        if (div_pend && !(done_seen || hz.EX_Div_Done)) begin
                            out_c.pc_hold     = 1'b1;
                            out_c.if_id_hold  = 1'b1;
                            out_c.id_ex_hold  = 1'b1;
                            out_c.ex_mem_hold = 1'b1;
                            state_nxt         = ST_DIV_WAIT;
                        end else begin
                            // Pipeline advances this cycle, so a pending load-use must still stall
                            state_nxt = ST_RUN;
                            if (load_use_c) begin
                                out_c.pc_hold     = 1'b1;
                                out_c.if_id_hold  = 1'b1;
                                out_c.id_ex_flush = 1'b1;
                            end
                        end
                    end
                end

                ST_DIV_WAIT: begin
                    if (hz.EX_Div_Done) begin
                        state_nxt = ST_RUN;
                    end else begin
                        out_c.pc_hold     = 1'b1;
                        out_c.if_id_hold  = 1'b1;
                        out_c.id_ex_hold  = 1'b1;
                        out_c.ex_mem_hold = 1'b1;
                    end
                end

                default: begin
                    if (hz.MEM_IO_Access && IO_EN) begin
                        out_c.pc_hold     = 1'b1;
                        out_c.if_id_hold  = 1'b1;
                        out_c.id_ex_hold  = 1'b1;
                        out_c.ex_mem_hold = 1'b1;
                        out_c.mem_wb_hold = 1'b1;
                        state_nxt         = ST_IO_WAIT;
                        cnt_nxt           = CNT_LOAD;
                        div_pend_nxt      = div_new_c;
                        done_seen_nxt     = 1'b0;
                    end else if (div_new_c) begin
                        out_c.pc_hold     = 1'b1;
                        out_c.if_id_hold  = 1'b1;
                        out_c.id_ex_hold  = 1'b1;
                        out_c.ex_mem_hold = 1'b1;
                        state_nxt         = ST_DIV_WAIT;
                    end else if (load_use_c) begin
                        out_c.pc_hold     = 1'b1;
                        out_c.if_id_hold  = 1'b1;
                        out_c.id_ex_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    assign hz.PC_Hold         = out_c.pc_hold;
    assign hz.IF_ID_Hold      = out_c.if_id_hold;
    assign hz.ID_EX_Hold      = out_c.id_ex_hold;
    assign hz.EX_MEM_Hold     = out_c.ex_mem_hold;
    assign hz.MEM_WB_Hold     = out_c.mem_wb_hold;
    assign hz.IF_ID_Flush     = out_c.if_id_flush;
    assign hz.ID_EX_Flush     = out_c.id_ex_flush;
    assign hz.EX_MEM_Flush    = out_c.ex_mem_flush;
    assign hz.PC_Sel_Redirect = out_c.pc_sel_redirect;
    assign hz.Div_Abort       = out_c.div_abort;
    // Unused encoding reads back as RUN
    assign hz.Ctrl_State      = ((state == ST_DIV_WAIT) || (state == ST_IO_WAIT)) ? state : ST_RUN;

endmodule
